cu_seq_ctrl: RTL and testbench

Parametrised multi-cycle control sequencer for the datapath CPU; it generalises the first-generation control unit. It drives the PC/MAR/MBR/IR/register-file/ALU/status control strobes and the MFA/MFC memory handshake through fetch, condition check, decode and execute of data-processing, load/store and branch instructions. It sits between the instruction register, the status register and the datapath register/ALU controls.

---
 rtl/cu_pkg.sv | 71 +++++++
 rtl/cu_seq_ctrl_if.sv | 51 +++++
 rtl/cu_cond_eval.sv | 46 ++++
 rtl/cu_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the cu_seq_ctrl control sequencer
//
// Purpose: state and condition-code encodings, ALU opcode constants, register
// select constants and the packed strobe bundle used by the sequencer.
// Ports: none (package).
package cu_pkg;

  // Sequencer states, 4-bit encoding; the four spare codes decode to FAULT.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_PCINC  = 4'd1,
    S_FWAIT  = 4'd2,
    S_IRLD   = 4'd3,
    S_COND   = 4'd4,
    S_DP     = 4'd5,
    S_LSADDR = 4'd6,
    S_LSDATA = 4'd7,
    S_LSMEM  = 4'd8,
    S_LSWB   = 4'd9,
    S_BR     = 4'd10,
    S_FAULT  = 4'd11
  } state_e;

  // ARM condition field IR[31:28].
  typedef enum logic [3:0] {
    CC_EQ = 4'd0,
    CC_NE = 4'd1,
    CC_CS = 4'd2,
    CC_CC = 4'd3,
    CC_MI = 4'd4,
    CC_PL = 4'd5,
    CC_VS = 4'd6,
    CC_VC = 4'd7,
    CC_HI = 4'd8,
    CC_LS = 4'd9,
    CC_GE = 4'd10,
    CC_LT = 4'd11,
    CC_GT = 4'd12,
    CC_LE = 4'd13,
    CC_AL = 4'd14,
    CC_NV = 4'd15
  } cond_e;

  // ALU operations issued by the sequencer itself (DP uses IR[24:21] directly).
  localparam int OP_SUB   = 2;
  localparam int OP_ADD   = 4;
  localparam int OP_INC4  = 17;
  localparam int OP_BRADD = 18;

  // Register-file select values driven on CU when IR_CU is high.
  localparam logic [3:0] CU_PC = 4'b1111;
  localparam logic [3:0] CU_RD = 4'b1110;

  // Single-bit datapath strobes, bundled so the decoder can default them at once.
  typedef struct packed {
    logic ir_cu;
    logic rfload;
    logic pcload;
    logic srload;
    logic srenabled;
    logic alustore;
    logic mfa;
    logic word_byte;
    logic read_write;
    logic irload;
    logic mbrload;
    logic mbrstore;
    logic marload;
  } strobe_t;

endpackage

// File: rtl/cu_seq_ctrl_if.sv
// rtl/cu_seq_ctrl_if.sv - sequencer <-> datapath/memory signal bundle
//
// Purpose: groups the instruction/status inputs, the memory handshake and all
// datapath control strobes of cu_seq_ctrl.
// Ports (master = sequencer side):
//   in : MFC (memory function complete), IR[DATA_W], SR[4] {N,Z,C,V}
//   out: IR_CU, RFLOAD, PCLOAD, SRLOAD, SRENABLED, ALUSTORE, MFA, WORD_BYTE,
//        READ_WRITE, IRLOAD, MBRLOAD, MBRSTORE, MARLOAD, opcode[OPC_W], CU[4],
//        instr_done, fault
interface cu_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5
);

  logic              MFC;
  logic [DATA_W-1:0] IR;
  logic [3:0]        SR;

  logic              IR_CU;
  logic              RFLOAD;
  logic              PCLOAD;
  logic              SRLOAD;
  logic              SRENABLED;
  logic              ALUSTORE;
  logic              MFA;
  logic              WORD_BYTE;
  logic              READ_WRITE;
  logic              IRLOAD;
  logic              MBRLOAD;
  logic              MBRSTORE;
  logic              MARLOAD;
  logic [OPC_W-1:0]  opcode;
  logic [3:0]        CU;
  logic              instr_done;
  logic              fault;

  modport master (
    input  MFC, IR, SR,
    output IR_CU, RFLOAD, PCLOAD, SRLOAD, SRENABLED, ALUSTORE, MFA, WORD_BYTE,
           READ_WRITE, IRLOAD, MBRLOAD, MBRSTORE, MARLOAD, opcode, CU,
           instr_done, fault
  );

  modport slave (
    output MFC, IR, SR,
    input  IR_CU, RFLOAD, PCLOAD, SRLOAD, SRENABLED, ALUSTORE, MFA, WORD_BYTE,
           READ_WRITE, IRLOAD, MBRLOAD, MBRSTORE, MARLOAD, opcode, CU,
           instr_done, fault
  );

endinterface

// File: rtl/cu_cond_eval.sv
// rtl/cu_cond_eval.sv - ARM condition-code evaluator
//
// Purpose: decides whether an instruction executes, from its condition field
// and the current status flags. Purely combinational.
// Ports:
//   cond[4] in  : IR[31:28]
//   sr[4]   in  : flags {N,Z,C,V}, N at bit 3
//   pass    out : 1 when the instruction should execute
module cu_cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] sr,
  output logic       pass
);

  logic n, z, c, v;

  assign n = sr[3];
  assign z = sr[2];
  assign c = sr[1];
  assign v = sr[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = ~z;
      CC_CS:   pass = c;
      CC_CC:   pass = ~c;
      CC_MI:   pass = n;
      CC_PL:   pass = ~n;
      CC_VS:   pass = v;
      CC_VC:   pass = ~v;
      CC_HI:   pass = c & ~z;
      CC_LS:   pass = ~c | z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = ~z & (n == v);
      CC_LE:   pass = z | (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_seq_ctrl.sv
// rtl/cu_seq_ctrl.sv - multi-cycle fetch/decode/execute control sequencer
//
// Purpose: Moore-style sequencer driving PC/MAR/MBR/IR/register-file/ALU/status
// strobes and the MFA/MFC memory handshake for data-processing, load/store
// and branch instructions.
// Ports:
//   Clk   in : clock, rising edge active
//   Reset in : asynchronous, active-high; forces FETCH and zeroes all outputs
//   bus      : cu_seq_ctrl_if.master (MFC/IR/SR in, strobes/opcode/CU/
//              instr_done/fault out)
// Optional feature: CU_MEM_TIMEOUT_EN adds a memory-wait watchdog that moves
// to FAULT once a wait has lasted WAIT_MAX cycles without MFC.
module cu_seq_ctrl
  import cu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic         Clk,
  input  logic         Reset,
  cu_seq_ctrl_if.master bus
);

  state_e           state;
  state_e           state_nxt;
  strobe_t          ctl;
  logic [OPC_W-1:0] opc;
  logic [3:0]       cu;
  logic             done;
  logic             cond_pass;
  logic             wait_tmo;

  // Only IR[31:20] is decoded; the remaining bits belong to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.IR;

  cu_cond_eval u_cond (
    .cond (bus.IR[31:28]),
    .sr   (bus.SR),
    .pass (cond_pass)
  );

`ifdef CU_MEM_TIMEOUT_EN
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;

  assign in_wait  = (state == S_FWAIT) || (state == S_LSMEM);
  // MFC arriving in the limit cycle still completes the access.
  assign wait_tmo = in_wait && !bus.MFC && (wait_cnt == CNT_W'(WAIT_MAX));

  // Held at zero outside wait states, so it always starts from 0 on entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (!in_wait) begin
      wait_cnt <= '0;
    end else if (!bus.MFC && !wait_tmo) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_wait_max = WAIT_MAX;
  assign wait_tmo = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    ctl       = '0;
    opc       = '0;
    cu        = '0;
    done      = 1'b0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        ctl.ir_cu   = 1'b1;
        cu          = CU_PC;
        ctl.marload = 1'b1;
        state_nxt   = S_PCINC;
      end
      S_PCINC: begin
        ctl.ir_cu  = 1'b1;
        cu         = CU_PC;
        opc        = OPC_W'(OP_INC4);
        ctl.pcload = 1'b1;
        state_nxt  = S_FWAIT;
      end
      S_FWAIT: begin
        ctl.mfa        = 1'b1;
        ctl.read_write = 1'b1;
        ctl.word_byte  = 1'b1;
        ctl.mbrload    = 1'b1;
        if (bus.MFC) begin
          state_nxt = S_IRLD;
        end else if (wait_tmo) begin
          state_nxt = S_FAULT;
        end
      end
      S_IRLD: begin
        ctl.irload = 1'b1;
        state_nxt  = S_COND;
      end
      S_COND: begin
        if (!cond_pass) begin
          // A skipped instruction still retires so instr_done counts every word.
          done      = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          casez (bus.IR[27:25])
            3'b00?:  state_nxt = S_DP;
            3'b01?:  state_nxt = S_LSADDR;
            3'b101:  state_nxt = S_BR;
            default: state_nxt = S_FAULT;
          endcase
        end
      end
      S_DP: begin
        opc           = OPC_W'(bus.IR[24:21]);
        ctl.srenabled = 1'b1;
        ctl.alustore  = 1'b1;
        ctl.srload    = bus.IR[20];
        // TST/TEQ/CMP/CMN only set flags and never write a register.
        ctl.rfload    = (bus.IR[24:23] != 2'b10);
        done          = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_LSADDR: begin
        opc          = bus.IR[23] ? OPC_W'(OP_ADD) : OPC_W'(OP_SUB);
        ctl.alustore = 1'b1;
        ctl.marload  = 1'b1;
        state_nxt    = bus.IR[20] ? S_LSMEM : S_LSDATA;
      end
      S_LSDATA: begin
        ctl.ir_cu   = 1'b1;
        cu          = CU_RD;
        ctl.mbrload = 1'b1;
        state_nxt   = S_LSMEM;
      end
      S_LSMEM: begin
        ctl.mfa        = 1'b1;
        ctl.read_write = bus.IR[20];
        ctl.word_byte  = ~bus.IR[22];
        if (bus.MFC) begin
          if (bus.IR[20]) begin
            state_nxt = S_LSWB;
          end else begin
            done      = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (wait_tmo) begin
          state_nxt = S_FAULT;
        end
      end
      S_LSWB: begin
        ctl.mbrstore = 1'b1;
        ctl.rfload   = 1'b1;
        done         = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BR: begin
        ctl.ir_cu  = 1'b1;
        cu         = CU_PC;
        opc        = OPC_W'(OP_BRADD);
        ctl.pcload = 1'b1;
        done       = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase
  end

  // Reset gates the outputs combinationally so they drop the moment it rises,
  // not at the next clock.
  assign bus.IR_CU      = ctl.ir_cu      & ~Reset;
  assign bus.RFLOAD     = ctl.rfload     & ~Reset;
  assign bus.PCLOAD     = ctl.pcload     & ~Reset;
  assign bus.SRLOAD     = ctl.srload     & ~Reset;
  assign bus.SRENABLED  = ctl.srenabled  & ~Reset;
  assign bus.ALUSTORE   = ctl.alustore   & ~Reset;
  assign bus.MFA        = ctl.mfa        & ~Reset;
  assign bus.WORD_BYTE  = ctl.word_byte  & ~Reset;
  assign bus.READ_WRITE = ctl.read_write & ~Reset;
  assign bus.IRLOAD     = ctl.irload     & ~Reset;
  assign bus.MBRLOAD    = ctl.mbrload    & ~Reset;
  assign bus.MBRSTORE   = ctl.mbrstore   & ~Reset;
  assign bus.MARLOAD    = ctl.marload    & ~Reset;
  assign bus.opcode     = Reset ? '0 : opc;
  assign bus.CU         = Reset ? 4'b0000 : cu;
  assign bus.instr_done = done & ~Reset;
  assign bus.fault      = (state == S_FAULT) & ~Reset;

endmodule

// File: tb/tb_cu_seq_ctrl.sv
// tb/tb_cu_seq_ctrl.sv - scoreboard testbench for cu_seq_ctrl
//
// Purpose: drives directed instructions through a latency-programmable memory
// model; a monitor checks each retired instruction against queued expectations.
// Ports: none (top-level bench). Honours CU_MEM_TIMEOUT_EN when defined.
module tb_cu_seq_ctrl;

  logic Clk;
  logic Reset;

  cu_seq_ctrl_if #(.DATA_W(32), .OPC_W(5)) bus_if ();

  cu_seq_ctrl #(.DATA_W(32), .OPC_W(5), .WAIT_MAX(15)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  typedef struct {
    string name;
    int    cyc;
    int    pcl;
    int    rfl;
    int    srl;
    int    op;
    int    dacc;
    int    rw;
    int    wb;
    int    rdsel;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fd      = 1000;
  int   dd      = 0;

  // Monitor accumulators, restarted at every FETCH.
  int cyc, pcl, rfl, srl, dacc, rdsel, rw, wb;

  localparam logic [23:0] FETCH_V = {1'b1, 11'b0, 1'b1, 5'd0, 4'hF, 2'b00};
  localparam logic [23:0] FAULT_V = 24'h000001;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [23:0] outs();
    return {bus_if.IR_CU, bus_if.RFLOAD, bus_if.PCLOAD, bus_if.SRLOAD,
            bus_if.SRENABLED, bus_if.ALUSTORE, bus_if.MFA, bus_if.WORD_BYTE,
            bus_if.READ_WRITE, bus_if.IRLOAD, bus_if.MBRLOAD, bus_if.MBRSTORE,
            bus_if.MARLOAD, bus_if.opcode, bus_if.CU, bus_if.instr_done,
            bus_if.fault};
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(string name, int c, int p, int r, int s, int op,
                              int da, int rwv, int wbv, int rd);
    exp_t e;
    e.name = name; e.cyc = c; e.pcl = p; e.rfl = r; e.srl = s; e.op = op;
    e.dacc = da; e.rw = rwv; e.wb = wbv; e.rdsel = rd;
    return e;
  endfunction

  // Memory: MFC rises after fd (fetch) or dd (data) wait cycles from access start.
  initial begin
    int  n;
    bit  in_acc;
    bit  acc_fetch;
    n = 0; in_acc = 0; acc_fetch = 0;
    bus_if.MFC = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus_if.MFA) begin
        if (!in_acc) begin
          in_acc    = 1;
          n         = 0;
          acc_fetch = bus_if.MBRLOAD;
        end else begin
          n++;
        end
        bus_if.MFC = (n >= (acc_fetch ? fd : dd));
      end else begin
        in_acc     = 0;
        bus_if.MFC = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation per instr_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (bus_if.MARLOAD && bus_if.IR_CU) begin
        cyc = 1; pcl = 0; rfl = 0; srl = 0; dacc = 0; rdsel = 0; rw = 0; wb = 0;
      end else begin
        cyc++;
      end
      if (bus_if.PCLOAD) pcl++;
      if (bus_if.RFLOAD) rfl++;
      if (bus_if.SRLOAD) srl++;
      if (bus_if.MFA && !bus_if.MBRLOAD) begin
        dacc = 1;
        rw   = int'(bus_if.READ_WRITE);
        wb   = int'(bus_if.WORD_BYTE);
      end
      if (bus_if.IR_CU && bus_if.CU == 4'b1110 && bus_if.MBRLOAD) rdsel++;
      if (bus_if.instr_done) begin
        if (q.size() == 0) begin
          chk("unexpected_instr_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_cycles"}, cyc, e.cyc);
          chk({e.name, "_pcload"}, pcl, e.pcl);
          chk({e.name, "_rfload"}, rfl, e.rfl);
          chk({e.name, "_srload"}, srl, e.srl);
          chk({e.name, "_opcode"}, int'(bus_if.opcode), e.op);
          chk({e.name, "_dacc"}, dacc, e.dacc);
          chk({e.name, "_rdsel"}, rdsel, e.rdsel);
          if (e.dacc != 0) begin
            chk({e.name, "_read_write"}, rw, e.rw);
            chk({e.name, "_word_byte"}, wb, e.wb);
          end
        end
      end
    end
  end

  task automatic run(input logic [31:0] ir, input logic [3:0] sr,
                     input int fdel, input int ddel, input exp_t e);
    #1;
    bus_if.IR = ir;
    bus_if.SR = sr;
    fd = fdel;
    dd = ddel;
    q.push_back(e);
    if (Reset) begin
      @(posedge Clk);
      #2;
      Reset = 1'b0;
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge Clk);
    if (q.size() != 0) begin
      chk({e.name, "_done_timeout"}, 0, 1);
      q.delete();
    end
  endtask

  initial begin
    int k;
    Reset     = 1'b1;
    bus_if.IR = 32'h0;
    bus_if.SR = 4'h0;
    fd = 1000;
    dd = 0;

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outs", int'(outs()), 0);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    @(negedge Clk);
    #3;
    chk("first_fetch", int'(outs()), int'(FETCH_V));
    repeat (5) @(negedge Clk);
    #3;
    chk("fwait_hold_mfa", int'(bus_if.MFA), 1);
    Reset = 1'b1;
    #1;
    chk("async_reset_mid_wait", int'(outs()), 0);

    run(32'hE0810002, 4'b0000, 0, 0, mk("add_al",   6, 1, 1, 0, 4,  0, 0, 0, 0));
    run(32'hE1510002, 4'b0000, 0, 0, mk("cmp_s",    6, 1, 0, 1, 10, 0, 0, 0, 0));
    run(32'h0A000004, 4'b0000, 0, 0, mk("beq_fail", 5, 1, 0, 0, 0,  0, 0, 0, 0));
    run(32'h0A000004, 4'b0100, 0, 0, mk("beq_pass", 6, 2, 0, 0, 18, 0, 0, 0, 0));
    run(32'hC0810002, 4'b1000, 0, 0, mk("gt_fail",  5, 1, 0, 0, 0,  0, 0, 0, 0));
    run(32'hC0810002, 4'b0000, 0, 0, mk("gt_pass",  6, 1, 1, 0, 4,  0, 0, 0, 0));
    run(32'hF0810002, 4'b0100, 0, 0, mk("nv_skip",  5, 1, 0, 0, 0,  0, 0, 0, 0));
    run(32'hE5912000, 4'b0000, 0, 3, mk("ldr_w3",   11, 1, 1, 0, 0, 1, 1, 1, 0));
    run(32'hE5C12000, 4'b0000, 0, 0, mk("strb",     8, 1, 0, 0, 0,  1, 0, 0, 1));
    run(32'hE0810002, 4'b0000, 2, 0, mk("add_fw2",  8, 1, 1, 0, 4,  0, 0, 0, 0));

    // Undefined class 100 must park the sequencer in FAULT.
    #1;
    bus_if.IR = 32'hE8000000;
    k = 0;
    while (!bus_if.fault && k < 30) begin
      @(negedge Clk);
      #3;
      k++;
    end
    chk("undef_fault_outs", int'(outs()), int'(FAULT_V));
    repeat (4) @(negedge Clk);
    #3;
    chk("fault_held", int'(outs()), int'(FAULT_V));
    Reset = 1'b1;
    #1;
    chk("fault_cleared_by_reset", int'(outs()), 0);

    // Fetch memory that never answers.
    fd = 1000;
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      #3;
`ifdef CU_MEM_TIMEOUT_EN
      if (c == 18) chk("tmo_not_yet", int'(bus_if.fault), 0);
      if (c == 19) chk("tmo_fault", int'(outs()), int'(FAULT_V));
      if (c == 40) chk("tmo_fault_held", int'(bus_if.fault), 1);
`else
      if (c == 40) chk("fwait_unbounded_mfa", int'(bus_if.MFA), 1);
      if (c == 40) chk("fwait_unbounded_nofault", int'(bus_if.fault), 0);
`endif
    end
    Reset = 1'b1;
    #1;
    chk("final_reset_outs", int'(outs()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
